// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one LIFO stack between NREQ requesters using round-robin arbitration.
// Pushes are masked while the stack is full and pops are masked while it is empty, so the
// stack's sticky overflow/underflow flags stay clear in normal operation.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_req_push, i_req_pop     per-requester level requests, held until granted
//   i_req_data                push data, requester i uses [i*WIDTH +: WIDTH]
//   o_grant                   one-hot single-cycle grant pulse
//   o_rsp_valid/_id/_data     pop response routed back to the popping requester
//   o_stk_push/_pop/_d        strobes and push data to the stack
//   i_stk_q                   stack output, valid the cycle after o_stk_pop
//   i_stk_overflow/_underflow stack sticky error flags
//   o_count, o_full, o_empty  occupancy tracking
//   o_error                   sticky, arbiter is in its error state
module stack_arbiter #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 7,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_push,
    input  logic [NREQ-1:0]       i_req_pop,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_rsp_valid,
    output logic [IDW-1:0]        o_rsp_id,
    output logic [WIDTH-1:0]      o_rsp_data,
    output logic                  o_stk_push,
    output logic                  o_stk_pop,
    output logic [WIDTH-1:0]      o_stk_d,
    input  logic [WIDTH-1:0]      i_stk_q,
    input  logic                  i_stk_overflow,
    input  logic                  i_stk_underflow,
    output logic [DEPTH-1:0]      o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_error
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp, StError} state_e;

    state_e             r_state,    w_state_next;
    logic [IDW-1:0]     r_rr_ptr,   w_rr_ptr_next;
    logic [DEPTH-1:0]   r_count,    w_count_next;
    logic [NREQ-1:0]    r_grant,    w_grant_next;
    logic               r_stk_push, w_stk_push_next;
    logic               r_stk_pop,  w_stk_pop_next;
    logic [WIDTH-1:0]   r_stk_d,    w_stk_d_next;
    logic [IDW-1:0]     r_gnt_id,   w_gnt_id_next;

    logic               w_full;
    logic               w_empty;
    logic [NREQ-1:0]    w_push_ok;
    logic [NREQ-1:0]    w_elig;
    logic               w_found;
    logic [IDW-1:0]     w_win;

    assign w_full    = (r_count == '1);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_req_push & {NREQ{~w_full}};
    assign w_elig    = w_push_ok | (i_req_pop & {NREQ{~w_empty}});

    // First eligible requester searching upward from r_rr_ptr with wrap.
    always_comb begin : arb
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_found && w_elig[IDW'(idx)]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rr_ptr_next   = r_rr_ptr;
        w_count_next    = r_count;
        w_grant_next    = '0;
        w_stk_push_next = 1'b0;
        w_stk_pop_next  = 1'b0;
        w_stk_d_next    = r_stk_d;
        w_gnt_id_next   = r_gnt_id;

        if (i_stk_overflow || i_stk_underflow) begin
            w_state_next = StError;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        w_state_next  = StIssue;
                        w_grant_next  = NREQ'(1) << w_win;
                        w_gnt_id_next = w_win;
                        w_rr_ptr_next = IDW'((32'(w_win) + 1) % NREQ);
                        // Push wins over pop for the same requester whenever it can be served.
                        if (w_push_ok[w_win]) begin
                            w_stk_push_next = 1'b1;
                            w_stk_d_next    = i_req_data[32'(w_win)*WIDTH +: WIDTH];
                        end else begin
                            w_stk_pop_next  = 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (r_stk_push) begin
                        w_count_next = r_count + 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_count_next = r_count - 1'b1;
                        w_state_next = StResp;
                    end
                end
                StResp: begin
                    w_state_next = StIdle;
                end
                StError: begin
                    w_state_next = StError;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_count    <= '0;
            r_grant    <= '0;
            r_stk_push <= 1'b0;
            r_stk_pop  <= 1'b0;
            r_stk_d    <= '0;
            r_gnt_id   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_count    <= w_count_next;
            r_grant    <= w_grant_next;
            r_stk_push <= w_stk_push_next;
            r_stk_pop  <= w_stk_pop_next;
            r_stk_d    <= w_stk_d_next;
            r_gnt_id   <= w_gnt_id_next;
        end
    end

    assign o_grant     = r_grant;
    assign o_stk_push  = r_stk_push;
    assign o_stk_pop   = r_stk_pop;
    assign o_stk_d     = r_stk_d;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_error     = (r_state == StError);

    // The stack presents popped data during the RESP cycle itself, so the response is qualified
    // by the registered state rather than captured again, keeping grant-to-response at 1 cycle.
    assign o_rsp_valid = (r_state == StResp);
    assign o_rsp_id    = o_rsp_valid ? r_gnt_id : '0;
    assign o_rsp_data  = o_rsp_valid ? i_stk_q : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Testbench for stack_arbiter: behavioural stack model, reference LIFO of pushed words and a
// response scoreboard checked whenever the arbiter returns pop data.
module tb_stack_arbiter;

    localparam int WIDTH = 11;
    localparam int DEPTH = 7;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_push = '0;
    logic [NREQ-1:0]       req_pop = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       grant;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  stk_push;
    logic                  stk_pop;
    logic [WIDTH-1:0]      stk_d;
    logic [WIDTH-1:0]      stk_q;
    logic                  stk_overflow;
    logic                  stk_underflow;
    logic [DEPTH-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  error;

    logic                  force_ovf = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   exp_ptr = 0;
    rsp_t exp_q[$];
    logic [WIDTH-1:0] ref_stk[$];
    rsp_t e_mon;

    always #5 clk = ~clk;

    stack_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .IDW(IDW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_push     (req_push),
        .i_req_pop      (req_pop),
        .i_req_data     (req_data),
        .o_grant        (grant),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_id       (rsp_id),
        .o_rsp_data     (rsp_data),
        .o_stk_push     (stk_push),
        .o_stk_pop      (stk_pop),
        .o_stk_d        (stk_d),
        .i_stk_q        (stk_q),
        .i_stk_overflow (stk_overflow),
        .i_stk_underflow(stk_underflow),
        .o_count        (count),
        .o_full         (full),
        .o_empty        (empty),
        .o_error        (error)
    );

    // Stack model: 128 slots, pointer wraps never; sticky flags on misuse.
    logic [WIDTH-1:0] m_mem [0:127];
    logic [6:0]       m_sp;
    logic [WIDTH-1:0] m_q;
    logic             m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sp  <= '0;
            m_q   <= '0;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            if (stk_push) begin
                if (m_sp == 7'd127) m_ovf <= 1'b1;
                else begin
                    m_mem[m_sp] <= stk_d;
                    m_sp        <= m_sp + 7'd1;
                end
            end
            if (stk_pop) begin
                if (m_sp == 7'd0) m_unf <= 1'b1;
                else begin
                    m_q  <= m_mem[m_sp - 7'd1];
                    m_sp <= m_sp - 7'd1;
                end
            end
        end
    end

    assign stk_q         = m_q;
    assign stk_overflow  = m_ovf | force_ovf;
    assign stk_underflow = m_unf;

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response",
                         rsp_id, rsp_data);
            end else begin
                e_mon = exp_q.pop_front();
                if (rsp_id !== e_mon.id || rsp_data !== e_mon.data) begin
                    errors++;
                    $display("FAIL rsp_match: got id=%0d data=%h, required id=%0d data=%h",
                             rsp_id, rsp_data, e_mon.id, e_mon.data);
                end
            end
        end
    end

    task automatic do_push(input int id, input logic [WIDTH-1:0] d);
        bit got = 0;
        req_data[id*WIDTH +: WIDTH] = d;
        req_push[id] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant[id]) got = 1;
        end
        checks++;
        if (!got || grant !== (4'b0001 << id) || stk_push !== 1'b1 || stk_d !== d) begin
            errors++;
            $display("FAIL push_grant: id=%0d grant=%b stk_push=%b stk_d=%h, required grant bit %0d stk_push=1 stk_d=%h",
                     id, grant, stk_push, stk_d, id, d);
        end
        req_push[id] = 1'b0;
        ref_stk.push_back(d);
        exp_ptr = (id + 1) % NREQ;
        @(negedge clk);
    endtask

    task automatic do_pop(input int id);
        bit   got = 0;
        rsp_t e;
        e.id   = IDW'(id);
        e.data = ref_stk.pop_back();
        exp_q.push_back(e);
        req_pop[id] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant[id]) got = 1;
        end
        checks++;
        if (!got || grant !== (4'b0001 << id) || stk_pop !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL pop_grant: id=%0d grant=%b stk_pop=%b stk_push=%b, required grant bit %0d stk_pop=1",
                     id, grant, stk_pop, stk_push, id);
        end
        req_pop[id] = 1'b0;
        exp_ptr = (id + 1) % NREQ;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== '0 || stk_push !== 1'b0 || stk_pop !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: grant=%b push=%b pop=%b rsp_valid=%b, required all 0",
                     grant, stk_push, stk_pop, rsp_valid);
        end
        checks++;
        if (stk_d !== '0 || rsp_data !== '0 || rsp_id !== '0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: stk_d=%h rsp_data=%h rsp_id=%0d error=%b, required all 0",
                     stk_d, rsp_data, rsp_id, error);
        end
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%0d empty=%b full=%b, required 0 1 0", count, empty, full);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_push();
        req_data[0 +: WIDTH] = 11'h155;
        req_push[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || stk_push !== 1'b1 || stk_d !== 11'h155) begin
            errors++;
            $display("FAIL first_push: grant=%b stk_push=%b stk_d=%h, required 0001 1 155",
                     grant, stk_push, stk_d);
        end
        req_push[0] = 1'b0;
        ref_stk.push_back(11'h155);
        exp_ptr = 1;
        @(negedge clk);
        checks++;
        if (count !== 7'd1 || empty !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL first_push_count: count=%0d empty=%b grant=%b, required 1 0 0000",
                     count, empty, grant);
        end
    endtask

    task automatic test_push_pop();
        bit   got = 0;
        rsp_t e;
        do_push(0, 11'h0AA);
        e.id   = 2'd2;
        e.data = ref_stk.pop_back();
        exp_q.push_back(e);
        req_pop[2] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (grant !== 4'b0100 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL pop_issue: grant=%b stk_pop=%b stk_push=%b, required 0100 1 0",
                     grant, stk_pop, stk_push);
        end
        req_pop[2] = 1'b0;
        exp_ptr = 3;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 11'h0AA) begin
            errors++;
            $display("FAIL pop_latency: rsp_valid=%b id=%0d data=%h, required 1 2 0aa",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (count !== 7'(ref_stk.size())) begin
            errors++;
            $display("FAIL pop_count: count=%0d, required %0d", count, ref_stk.size());
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] cur_d [NREQ];
        int reraise = -1;
        for (int i = 0; i < NREQ; i++) begin
            cur_d[i] = 11'h100 + 11'(i);
            req_data[i*WIDTH +: WIDTH] = cur_d[i];
        end
        req_push = '1;
        for (int g = 0; g < 8; g++) begin
            int cyc = 0;
            bit got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                cyc++;
                if (reraise >= 0) begin
                    cur_d[reraise] = cur_d[reraise] + 11'h010;
                    req_data[reraise*WIDTH +: WIDTH] = cur_d[reraise];
                    req_push[reraise] = 1'b1;
                    reraise = -1;
                end
                if (grant != '0) got = 1;
            end
            checks++;
            if (grant !== (4'b0001 << exp_ptr) || stk_d !== cur_d[exp_ptr] || (g > 0 && cyc != 2)) begin
                errors++;
                $display("FAIL rr_order: step=%0d grant=%b stk_d=%h gap=%0d, required grant bit %0d stk_d=%h gap=2",
                         g, grant, stk_d, cyc, exp_ptr, cur_d[exp_ptr]);
            end
            ref_stk.push_back(cur_d[exp_ptr]);
            req_push[exp_ptr] = 1'b0;
            reraise = exp_ptr;
            exp_ptr = (exp_ptr + 1) % NREQ;
            if (g == 7) begin
                req_push = '0;
                reraise  = -1;
            end
        end
        @(negedge clk);
        repeat (3) do_pop(1);
    endtask

    task automatic test_full();
        bit   got = 0;
        rsp_t e;
        int   k = 0;
        while (ref_stk.size() < 127) begin
            do_push(0, 11'(k * 13 + 5));
            k++;
        end
        checks++;
        if (count !== 7'd127 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill: count=%0d full=%b, required 127 1", count, full);
        end
        e.id   = 2'd3;
        e.data = ref_stk.pop_back();
        exp_q.push_back(e);
        req_data[1*WIDTH +: WIDTH] = 11'h7E1;
        req_push[1] = 1'b1;
        req_pop[3]  = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (grant !== 4'b1000 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL full_mask: grant=%b stk_pop=%b stk_push=%b, required 1000 1 0",
                     grant, stk_pop, stk_push);
        end
        req_pop[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL full_drop: full=%b, required 0", full);
        end
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (grant !== 4'b0010 || stk_push !== 1'b1 || stk_d !== 11'h7E1) begin
            errors++;
            $display("FAIL full_refill: grant=%b stk_push=%b stk_d=%h, required 0010 1 7e1",
                     grant, stk_push, stk_d);
        end
        req_push[1] = 1'b0;
        ref_stk.push_back(11'h7E1);
        exp_ptr = 2;
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_again: full=%b overflow=%b, required 1 0", full, m_ovf);
        end
        while (ref_stk.size() > 0) do_pop(2);
        checks++;
        if (empty !== 1'b1 || count !== '0 || m_unf !== 1'b0) begin
            errors++;
            $display("FAIL drain: empty=%b count=%0d underflow=%b, required 1 0 0", empty, count, m_unf);
        end
    endtask

    task automatic test_empty_pop();
        bit   saw = 0;
        bit   got = 0;
        rsp_t e;
        req_pop[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (grant != '0 || stk_pop) saw = 1;
        end
        checks++;
        if (saw || m_unf !== 1'b0) begin
            errors++;
            $display("FAIL empty_mask: grant_seen=%b underflow=%b, required 0 0", saw, m_unf);
        end
        req_data[1*WIDTH +: WIDTH] = 11'h033;
        req_push[1] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (grant !== 4'b0010 || stk_push !== 1'b1) begin
            errors++;
            $display("FAIL empty_push: grant=%b stk_push=%b, required 0010 1", grant, stk_push);
        end
        req_push[1] = 1'b0;
        e.id   = 2'd0;
        e.data = 11'h033;
        exp_q.push_back(e);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (grant !== 4'b0001 || stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop_served: grant=%b stk_pop=%b, required 0001 1", grant, stk_pop);
        end
        req_pop[0] = 1'b0;
        exp_ptr = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_error();
        bit saw = 0;
        force_ovf = 1'b1;
        @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_set: error=%b, required 1", error);
        end
        force_ovf = 1'b0;
        req_data[0 +: WIDTH] = 11'h111;
        req_push[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (grant != '0 || stk_push || stk_pop || error !== 1'b1) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL error_sticky: activity_or_error_clear=%b, required 0", saw);
        end
        req_push = '0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_reset: error=%b, required 0", error);
        end
        rst_n = 1'b1;
        ref_stk.delete();
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pop();
        bit got = 0;
        bit saw = 0;
        do_push(0, 11'h2A5);
        req_pop[1] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        checks++;
        if (!got || stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL midpop_issue: grant=%b stk_pop=%b, required pop issued", grant, stk_pop);
        end
        rst_n = 1'b0;
        req_pop = '0;
        #1;
        checks++;
        if (grant !== '0 || stk_pop !== 1'b0 || stk_push !== 1'b0 || stk_d !== '0 ||
            rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || count !== '0 ||
            error !== 1'b0) begin
            errors++;
            $display("FAIL midpop_reset: grant=%b pop=%b push=%b d=%h rv=%b id=%0d rd=%h count=%0d err=%b, required all 0",
                     grant, stk_pop, stk_push, stk_d, rsp_valid, rsp_id, rsp_data, count, error);
        end
        ref_stk.delete();
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL midpop_no_rsp: rsp_valid_seen=%b, required 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_push_pop();
        test_round_robin();
        test_full();
        test_empty_pop();
        test_error();
        test_reset_mid_pop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: outstanding=%0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack instance (WIDTH-bit data, 2**DEPTH slots) between NREQ independent requesters.
- Round-robin arbitration; at most one push or pop is issued to the stack every 2 cycles.
- Tracks occupancy and masks pushes when full and pops when empty, so the stack's sticky overflow/underflow flags are never set in normal operation.
- Sits between requester clients and the stack. Pop data is routed back to the requester that issued the pop, tagged with its ID.

Parameters:
- WIDTH, 11, data width; must match the stack.
- DEPTH, 7, stack pointer width; usable capacity is 2**DEPTH-1 entries.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_push  in  NREQ  per-requester push request; level, held until granted.
- req_pop  in  NREQ  per-requester pop request; level, held until granted.
- req_data  in  NREQ*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot, single-cycle grant pulse.
- rsp_valid  out  1  pop data valid, one-cycle pulse.
- rsp_id  out  IDW  requester that receives rsp_data.
- rsp_data  out  WIDTH  popped word.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_d  out  WIDTH  push data to the stack.
- stk_q  in  WIDTH  stack output; valid the cycle after stk_pop.
- stk_overflow  in  1  stack sticky overflow flag.
- stk_underflow  in  1  stack sticky underflow flag.
- count  out  DEPTH  current occupancy.
- full  out  1  count == 2**DEPTH-1.
- empty  out  1  count == 0.
- error  out  1  sticky; arbiter is in ERROR state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, count=0.
  - grant, stk_push, stk_pop, rsp_valid, error are 0; stk_d, rsp_data, rsp_id are 0.
  - Reset mid-operation aborts any in-flight pop; no rsp_valid is issued for it.
- Eligibility: requester i is eligible if (req_push[i] && !full) || (req_pop[i] && !empty).
  - If both req_push[i] and req_pop[i] are set, push is served when not full; otherwise pop is served.
  - Ineligible requests stay pending and are not dropped.
- Arbitration: the first eligible index searching from rr_ptr upward, wrapping at NREQ-1 to 0. After a grant to i, rr_ptr <= (i+1) mod NREQ.
- State machine (all outputs registered):
  - IDLE: if any requester is eligible and stk_overflow|stk_underflow is 0, go to ISSUE next cycle. In that same transition set grant[i]=1, plus either stk_push=1 with stk_d=req_data[i], or stk_pop=1.
  - ISSUE: lasts one cycle; grant, stk_push and stk_pop are high only here.
    - Push: count+1, then return to IDLE.
    - Pop: count-1, then go to RESP.
    - The granted requester must drop its request in the ISSUE cycle. Arbitration does not sample requests in ISSUE.
  - RESP: rsp_valid=1, rsp_data<=stk_q, rsp_id=granted index; then IDLE. Pop latency is grant to rsp_valid = 1 cycle.
  - ERROR: entered from any state when stk_overflow or stk_underflow is sampled high.
    - error=1; no further grants or strobes are issued.
    - Left only by reset.
- Count: wraps never. Increment is masked at 2**DEPTH-1 and decrement is masked at 0 by the eligibility rule.
- Throughput: push = 1 operation per 2 cycles; pop = 1 operation per 3 cycles.

Test Plan:
- Reset, then req0 pushes 0x155 -> grant=0001 and stk_push=1 with stk_d=0x155 one cycle later; count=1; empty=0.
- req0 pushes 0x0AA, then req2 pops -> stk_pop pulses, then the next cycle has rsp_valid=1, rsp_id=2, rsp_data=0x0AA; count returns to prior value.
- All 4 requesters push continuously -> grant order is 0,1,2,3,0,... with each grant 2 cycles apart; no requester is starved.
- Fill to 127 entries, then req1 push plus req3 pop pending -> req1 is masked, req3 is granted, and after the pop req1 is granted; full toggles 1->0->1.
- From empty, req0 pops -> no grant, stk_pop never asserts, stk_underflow stays 0; req0 is granted once a push lands.
- Force stk_overflow=1 -> error=1 the next cycle with no further grants; assert reset low mid-pop -> all outputs 0 immediately and no rsp_valid.
